bigmul_unit_csa: RTL and testbench

Multi-precision integer multiplier: multiplies two 4096-bit operands held in internal operand stores A and B (64 × 64-bit words each, little-endian word order) and writes the 8192-bit product into an internal result store (128 × 64-bit words). Word-level partial products accumulate in redundant (carry-deferred) column form. A single carry-propagate pass then normalises the columns. The unit is a standalone accelerator. Operands are loaded and results read through simulation backdoor tasks. Control is start/busy/compute_done.

---
 rtl/bigmul_unit_csa.sv | 103 ++++++++++
 tb/tb_bigmul_unit_csa.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bigmul_unit_csa.sv
// 4096 x 4096-bit unsigned multiplier: one 64x64 word product per cycle, accumulated
// into deferred-carry columns, then one carry-propagate pass writes the 8192-bit product.
module bigmul_unit_csa (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic busy,
  output logic compute_done
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t       state_q, state_d;
  logic [5:0]   i_q, j_q;
  logic [6:0]   k_q;
  logic [8:0]   carry_q;

  logic [63:0]  cacheA [0:63];
  logic [63:0]  cacheB [0:63];
  logic [63:0]  result [0:127];
  logic [71:0]  col    [0:127];

  logic         accept;
  logic         mul_last;
  logic [127:0] prod;
  logic [6:0]   col_idx;
  logic [72:0]  norm_sum;

  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign mul_last = (i_q == 6'd63) && (j_q == 6'd63);
  assign prod     = {64'd0, cacheA[i_q]} * {64'd0, cacheB[j_q]};
  assign col_idx  = {1'b0, i_q} + {1'b0, j_q};
  assign norm_sum = {1'b0, col[k_q]} + {64'd0, carry_q};

  assign busy         = (state_q == MUL) || (state_q == NORM);
  assign compute_done = (state_q == DONE);

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)           state_d = MUL;
      MUL:        if (mul_last)        state_d = NORM;
      NORM:       if (k_q == 7'd127)   state_d = DONE;
      default:                         state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        i_q <= '0;
        j_q <= '0;
      end else if (state_q == MUL) begin
        j_q <= j_q + 6'd1;
        if (j_q == 6'd63) i_q <= i_q + 6'd1;
        if (mul_last) begin
          k_q     <= '0;
          carry_q <= '0;
        end
      end else if (state_q == NORM) begin
        k_q     <= k_q + 7'd1;
        carry_q <= norm_sum[72:64];
      end
    end
  end

  // NOTE: column and result stores are deliberately outside the reset domain; they are
  // cleared or overwritten by the sequence itself, and result must survive a reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < 128; c++) col[c] <= '0;
    end else if (state_q == MUL) begin
      // Low and high halves land in adjacent columns; carries between columns wait for NORM.
      col[col_idx]        <= col[col_idx]        + {8'd0, prod[63:0]};
      col[col_idx + 7'd1] <= col[col_idx + 7'd1] + {8'd0, prod[127:64]};
    end else if (state_q == NORM) begin
      result[k_q] <= norm_sum[63:0];
    end
  end

  // Simulation backdoor access to the operand and result stores.
  task automatic write_cacheA(input logic [5:0] idx, input logic [63:0] data);
    cacheA[idx] = data;
  endtask

  task automatic write_cacheB(input logic [5:0] idx, input logic [63:0] data);
    cacheB[idx] = data;
  endtask

  function automatic logic [63:0] read_result(input logic [6:0] idx);
    return result[idx];
  endfunction

endmodule

// File: tb/tb_bigmul_unit_csa.sv
// Self-checking bench for bigmul_unit_csa: directed corner operands plus random operands
// checked against a wide-integer multiply, with latency, ignored-start and reset scenarios.
module tb_bigmul_unit_csa;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic compute_done;

  int checks = 0;
  int errors = 0;

  logic [63:0] op_a  [64];
  logic [63:0] op_b  [64];
  logic [63:0] exp_w [128];

  localparam int LATENCY = 4224;
  localparam int BUDGET  = 5000;

  bigmul_unit_csa dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .busy         (busy),
    .compute_done (compute_done)
  );

  always #5 clk = ~clk;

  task automatic zero_ops();
    for (int i = 0; i < 64; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
  endtask

  task automatic random_ops();
    for (int i = 0; i < 64; i++) begin
      op_a[i] = {$urandom, $urandom};
      op_b[i] = {$urandom, $urandom};
    end
  endtask

  task automatic load_dut();
    for (int i = 0; i < 64; i++) begin
      dut.write_cacheA(6'(i), op_a[i]);
      dut.write_cacheB(6'(i), op_b[i]);
    end
  endtask

  // Reference: plain wide-integer product of the two packed operands.
  task automatic compute_model();
    logic [8191:0] a_big, b_big, p_big;
    a_big = '0;
    b_big = '0;
    for (int i = 0; i < 64; i++) begin
      a_big[64*i +: 64] = op_a[i];
      b_big[64*i +: 64] = op_b[i];
    end
    p_big = a_big * b_big;
    for (int k = 0; k < 128; k++) exp_w[k] = p_big[64*k +: 64];
  endtask

  // Called #1 after an edge; start is seen at the next edge (E0).
  task automatic start_and_wait(output int cycles, output logic busy_e0, output logic done_e0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    busy_e0 = busy;
    done_e0 = compute_done;
    cycles  = 0;
    while (compute_done !== 1'b1 && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || compute_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b, required 0/0", busy, compute_done);
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || compute_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b, required 0/0", c, busy, compute_done);
      end
    end
  endtask

  task automatic test_small();
    int cycles;
    logic b0, d0;
    zero_ops();
    op_a[0] = 64'd3;
    op_b[0] = 64'd5;
    load_dut();
    for (int k = 0; k < 128; k++) exp_w[k] = '0;
    exp_w[0] = 64'h0000_0000_0000_000F;
    start_and_wait(cycles, b0, d0);
    checks++;
    if (b0 !== 1'b1 || d0 !== 1'b0) begin
      errors++;
      $display("FAIL small_e0: busy=%b done=%b, required 1/0", b0, d0);
    end
    checks++;
    if (cycles != LATENCY) begin
      errors++;
      $display("FAIL small_latency: %0d edges, required %0d", cycles, LATENCY);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL small_busy_at_done: busy=%b, required 0", busy);
    end
    for (int k = 0; k < 128; k++) begin
      checks++;
      if (dut.read_result(7'(k)) !== exp_w[k]) begin
        errors++;
        $display("FAIL small_word %0d: got %h, required %h", k, dut.read_result(7'(k)), exp_w[k]);
      end
    end
  endtask

  task automatic test_all_ones();
    int cycles;
    logic b0, d0;
    for (int i = 0; i < 64; i++) begin
      op_a[i] = '1;
      op_b[i] = '1;
    end
    load_dut();
    exp_w[0] = 64'h0000_0000_0000_0001;
    for (int k = 1; k < 64; k++) exp_w[k] = '0;
    exp_w[64] = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int k = 65; k < 128; k++) exp_w[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    start_and_wait(cycles, b0, d0);
    checks++;
    if (cycles != LATENCY) begin
      errors++;
      $display("FAIL ones_latency: %0d edges, required %0d", cycles, LATENCY);
    end
    for (int k = 0; k < 128; k++) begin
      checks++;
      if (dut.read_result(7'(k)) !== exp_w[k]) begin
        errors++;
        $display("FAIL ones_word %0d: got %h, required %h", k, dut.read_result(7'(k)), exp_w[k]);
      end
    end
  endtask

  task automatic test_top_words();
    int cycles;
    logic b0, d0;
    zero_ops();
    op_a[63] = '1;
    op_b[63] = '1;
    load_dut();
    for (int k = 0; k < 128; k++) exp_w[k] = '0;
    exp_w[126] = 64'h0000_0000_0000_0001;
    exp_w[127] = 64'hFFFF_FFFF_FFFF_FFFE;
    start_and_wait(cycles, b0, d0);
    checks++;
    if (cycles != LATENCY) begin
      errors++;
      $display("FAIL top_latency: %0d edges, required %0d", cycles, LATENCY);
    end
    for (int k = 0; k < 128; k++) begin
      checks++;
      if (dut.read_result(7'(k)) !== exp_w[k]) begin
        errors++;
        $display("FAIL top_word %0d: got %h, required %h", k, dut.read_result(7'(k)), exp_w[k]);
      end
    end
  endtask

  // Random operands; a second start at cycle 100 must be ignored and old results must persist.
  task automatic test_start_ignored();
    int cycles;
    logic [63:0] old_w3;
    old_w3 = exp_w[3];
    random_ops();
    load_dut();
    compute_model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (compute_done !== 1'b1 && cycles < BUDGET) begin
      start = (cycles == 99);
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 150) begin
        checks++;
        if (dut.read_result(7'd3) !== old_w3) begin
          errors++;
          $display("FAIL hold_before_norm: word3=%h, required %h", dut.read_result(7'd3), old_w3);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (cycles != LATENCY) begin
      errors++;
      $display("FAIL ignored_start_latency: %0d edges, required %0d", cycles, LATENCY);
    end
    for (int k = 0; k < 128; k++) begin
      checks++;
      if (dut.read_result(7'(k)) !== exp_w[k]) begin
        errors++;
        $display("FAIL rand_word %0d: got %h, required %h", k, dut.read_result(7'(k)), exp_w[k]);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int cycles;
    logic b0, d0;
    random_ops();
    load_dut();
    compute_model();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (500) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || compute_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop: busy=%b done=%b, required 0/0", busy, compute_done);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || compute_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b done=%b, required 0/0", busy, compute_done);
    end
    start_and_wait(cycles, b0, d0);
    checks++;
    if (cycles != LATENCY) begin
      errors++;
      $display("FAIL midreset_latency: %0d edges, required %0d", cycles, LATENCY);
    end
    for (int k = 0; k < 128; k++) begin
      checks++;
      if (dut.read_result(7'(k)) !== exp_w[k]) begin
        errors++;
        $display("FAIL midreset_word %0d: got %h, required %h", k, dut.read_result(7'(k)), exp_w[k]);
      end
    end
  endtask

  // Restart straight from DONE: done must clear at E0 and stay sticky after completion.
  task automatic test_back_to_back();
    int cycles;
    logic b0, d0;
    random_ops();
    load_dut();
    compute_model();
    start_and_wait(cycles, b0, d0);
    checks++;
    if (b0 !== 1'b1 || d0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_e0: busy=%b done=%b, required 1/0", b0, d0);
    end
    checks++;
    if (cycles != LATENCY) begin
      errors++;
      $display("FAIL b2b_latency: %0d edges, required %0d", cycles, LATENCY);
    end
    for (int k = 0; k < 128; k++) begin
      checks++;
      if (dut.read_result(7'(k)) !== exp_w[k]) begin
        errors++;
        $display("FAIL b2b_word %0d: got %h, required %h", k, dut.read_result(7'(k)), exp_w[k]);
      end
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (compute_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_sticky: busy=%b done=%b, required 0/1", busy, compute_done);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_all_ones();
    test_top_words();
    test_start_ignored();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
